md_unit: RTL and testbench

Multi-cycle multiply/divide unit for the MIPS pipeline, placed in the EX stage beside the single-cycle ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO and holds the architectural HI/LO registers. It exposes `busy` and `stall_req` so hazard logic can freeze instructions that read or write HI/LO while an operation is in flight.

---
 rtl/md_unit_if.sv | 13 +
 rtl/md_unit.sv | 68 ++++++
 tb/tb_md_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// md_unit_if: request and HI/LO result signals between the pipeline and the multiply/divide unit.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master (output start, md_op, A, B, input busy, stall_req, HI, LO);
  modport slave  (input start, md_op, A, B, output busy, stall_req, HI, LO);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU with MTHI/MTLO and the architectural HI/LO registers.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    md_unit_if.slave md
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state, state_n;
    logic [31:0] cnt, a_q, b_q, hi_q, lo_q;
    logic [1:0]  op_q;
    logic [31:0] ma, mb, q, r, res_hi, res_lo;
    logic        na, nb, div_zero, launch;
    logic [63:0] prod;
    assign launch       = md.start && !md.md_op[2];
    assign md.busy      = state == RUN;
    assign md.stall_req = md.start | md.busy;
    assign md.HI        = hi_q;
    assign md.LO        = lo_q;
    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = launch ? RUN : IDLE;
        else state_n = cnt == 32'd1 ? IDLE : RUN;
    end
    // Signed ops work on magnitudes so INT_MIN / -1 needs no special case.
    always_comb begin
        na       = ~op_q[0] & a_q[31];
        nb       = ~op_q[0] & b_q[31];
        ma       = na ? -a_q : a_q;
        mb       = nb ? -b_q : b_q;
        div_zero = b_q == 32'd0;
        q        = div_zero ? '0 : ma / mb;
        r        = div_zero ? '0 : ma % mb;
        prod     = {{32{na}}, a_q} * {{32{nb}}, b_q};
        res_hi   = op_q[1] ? (na ? -r : r) : prod[63:32];
        res_lo   = op_q[1] ? ((na ^ nb) ? -q : q) : prod[31:0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                if (launch) begin
                    op_q <= md.md_op[1:0];
                    a_q  <= md.A;
                    b_q  <= md.B;
                    cnt  <= md.md_op[1] ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                end else if (md.md_op == 3'b100) hi_q <= md.A;
                else if (md.md_op == 3'b101) lo_q <= md.A;
            end else begin
                cnt <= cnt - 32'd1;
                if (cnt == 32'd1 && !(op_q[1] && div_zero)) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit.
module tb_md_unit;
    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;
    exp_t sb[$];
    always #5 clk = ~clk;
    md_unit_if bus ();
    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(bus.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic st);
        bus.start = st;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
    endtask

    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(op, a, b, 1'b1);
        #1 chk({tag, " stall_req"}, 32'(bus.stall_req), 32'd1);
        @(negedge clk);
        drive(3'b110, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic launch(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int n);
        exp_t e;
        e.tag = tag; e.hi = ehi; e.lo = elo; e.n = n;
        sb.push_back(e);
        issue(tag, op, a, b);
    endtask

    task automatic finish(input bit disturb);
        exp_t e;
        logic [31:0] ph, pl;
        int cnt;
        bit ok;
        ph = bus.HI; pl = bus.LO; cnt = 0; ok = 1'b1;
        e = sb.pop_front();
        while (bus.busy && cnt < 100) begin
            cnt++;
            ok &= (bus.HI === ph) && (bus.LO === pl) && (bus.stall_req === 1'b1);
            if (disturb && cnt == 2) drive(3'b011, 32'd9, 32'd0, 1'b1);
            else if (disturb && cnt == 3) drive(3'b100, 32'hDEAD, 32'd0, 1'b0);
            else drive(3'b110, 32'd0, 32'd0, 1'b0);
            @(negedge clk);
        end
        chk({e.tag, " busy cycles"}, 32'(cnt), 32'(e.n));
        chk({e.tag, " HI/LO held, stall during run"}, 32'(ok), 32'd1);
        chk({e.tag, " HI"}, bus.HI, e.hi);
        chk({e.tag, " LO"}, bus.LO, e.lo);
    endtask

    task automatic move(input string tag, input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        drive(op, a, 32'd0, 1'b0);
        @(negedge clk);
        drive(3'b110, 32'd0, 32'd0, 1'b0);
        chk(tag, op[0] ? bus.LO : bus.HI, a);
        chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bit held;
        drive(3'b110, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset HI", bus.HI, 32'd0);
        chk("reset LO", bus.LO, 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        launch("MULT -1*2", 3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        finish(1'b0);
        launch("MULTU", 3'b001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
        finish(1'b0);
        launch("DIV -7/2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        finish(1'b0);
        launch("DIVU 7/2", 3'b011, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        finish(1'b0);
        launch("DIV min/-1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
        finish(1'b0);
        move("MTHI", 3'b100, 32'h11);
        move("MTLO", 3'b101, 32'h22);
        launch("DIV by zero", 3'b010, 32'd5, 32'd0, 32'h11, 32'h22, 10);
        finish(1'b0);
        launch("MULT with interference", 3'b000, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        finish(1'b1);
        chk("no restart after interference", 32'(bus.busy), 32'd0);
        issue("MULT aborted", 3'b000, 32'd7, 32'd9);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async reset HI", bus.HI, 32'd0);
        chk("async reset LO", bus.LO, 32'd0);
        chk("async reset busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        held = 1'b1;
        repeat (8) begin
            @(negedge clk);
            held &= (bus.LO === 32'd0) && (bus.HI === 32'd0) && (bus.busy === 1'b0);
        end
        chk("aborted result never written", 32'(held), 32'd1);
        launch("MULTU 2*2 after abort", 3'b001, 32'd2, 32'd2, 32'd0, 32'd4, 5);
        finish(1'b0);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
